// File: rtl/board_mem_arbiter.sv
// Board memory arbiter: shares one single-port synchronous RAM (1-cycle read
// latency) between the VGA square fetch and a CPU req/ack port.
module board_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 16
) (
    input  logic              iVGA_CLK,
    input  logic              iRST,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    // State names the grant issued in a cycle; state_q carries it one cycle
    // on, so it tells which requester owns mem_rdata right now.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VGA_RD  = 3'd1,
        CPU_RD  = 3'd2,
        CPU_WR  = 3'd3,
        CPU_ERR = 3'd4
    } state_e;

    state_e              grant;
    state_e              cpu_op;
    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic [CNT_W-1:0]    starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0]   last_addr_q, last_addr_d;
    logic                miss1_q, miss1_d;
    logic                vga_miss_q, vga_miss_d;
    logic                vga_valid_q, vga_valid_d;
    logic [DATA_W-1:0]   vga_data_q, vga_data_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;

    logic                cpu_seen;
    logic                cpu_in_range;
    logic                cpu_pend;
    logic                cpu_bad;
    logic                vga_gnt;
    logic                cpu_gnt;
    logic [ADDR_W-1:0]   addr_sel;

    // CPU handshake: cpu_req is held with stable we/addr/wdata until the
    // one-cycle cpu_ack; between acceptance and ack the port is busy and
    // cpu_req is not looked at, so dropping it early cannot cancel the op.
    always_comb begin
        cpu_seen     = cpu_req && !busy_q;
        cpu_in_range = (cpu_addr[ADDR_W-1:6] == '0);
        cpu_pend     = cpu_seen && cpu_in_range;
        cpu_bad      = cpu_seen && !cpu_in_range;
        cpu_op       = cpu_we ? CPU_WR : CPU_RD;

        if (cpu_pend && (starve_cnt_q == STARVE_LIM)) begin
            grant = cpu_op;
        end else if (vga_req) begin
            grant = VGA_RD;
        end else if (cpu_pend) begin
            grant = cpu_op;
        end else if (cpu_bad) begin
            grant = CPU_ERR;
        end else begin
            grant = IDLE;
        end

        vga_gnt = (grant == VGA_RD);
        cpu_gnt = (grant == CPU_RD) || (grant == CPU_WR);

        if (vga_gnt) begin
            addr_sel = vga_addr;
        end else if (cpu_gnt) begin
            addr_sel = cpu_addr;
        end else begin
            addr_sel = last_addr_q;
        end
    end

    // The RAM samples its address in the grant cycle, so the memory port is
    // driven straight from the arbitration result, forced quiet in reset.
    always_comb begin
        mem_addr  = iRST ? '0 : addr_sel;
        mem_we    = !iRST && (grant == CPU_WR);
        mem_wdata = iRST ? '0 : cpu_wdata;
    end

    always_comb begin
        state_d     = grant;
        last_addr_d = (vga_gnt || cpu_gnt) ? addr_sel : last_addr_q;

        if (cpu_gnt || !cpu_pend) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q == STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        busy_d = busy_q;
        if (cpu_ack_q) begin
            busy_d = 1'b0;
        end
        if (cpu_gnt || cpu_bad) begin
            busy_d = 1'b1;
        end

        miss1_d     = vga_req && !vga_gnt;
        vga_miss_d  = miss1_q;
        vga_valid_d = (state_q == VGA_RD);
        vga_data_d  = (state_q == VGA_RD) ? mem_rdata : vga_data_q;

        // Writes and range errors ack one cycle after acceptance, reads two.
        cpu_ack_d = (state_q == CPU_RD) || (grant == CPU_WR) || cpu_bad;
        cpu_err_d = cpu_bad;
        if (state_q == CPU_RD) begin
            cpu_rdata_d = mem_rdata;
        end else if (cpu_bad) begin
            cpu_rdata_d = '0;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end
    end

    always_ff @(posedge iVGA_CLK or posedge iRST) begin
        if (iRST) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            starve_cnt_q <= '0;
            last_addr_q  <= '0;
            miss1_q      <= 1'b0;
            vga_miss_q   <= 1'b0;
            vga_valid_q  <= 1'b0;
            vga_data_q   <= '0;
            cpu_ack_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            starve_cnt_q <= starve_cnt_d;
            last_addr_q  <= last_addr_d;
            miss1_q      <= miss1_d;
            vga_miss_q   <= vga_miss_d;
            vga_valid_q  <= vga_valid_d;
            vga_data_q   <= vga_data_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
        end
    end

    assign vga_data  = vga_data_q;
    assign vga_valid = vga_valid_q;
    assign vga_miss  = vga_miss_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_err   = cpu_err_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Randomized bench for board_mem_arbiter: a cycle-level reference model of the
// grant rules feeds expected responses to a scoreboard checked by a monitor.
module tb_board_mem_arbiter;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 16;
    localparam int DEPTH      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              vga_req = 1'b0;
    logic [ADDR_W-1:0] vga_addr = '0;
    logic [DATA_W-1:0] vga_data;
    logic              vga_valid;
    logic              vga_miss;
    logic              cpu_req = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        dbg_state;

    board_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .iVGA_CLK(clk), .iRST(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data),
        .vga_valid(vga_valid), .vga_miss(vga_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .cpu_err(cpu_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- board RAM (environment) ----------------
    function automatic logic [DATA_W-1:0] init_val(input int a);
        return DATA_W'(a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    logic [DATA_W-1:0] ram [0:DEPTH-1];
    bit                written [0:DEPTH-1];

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int                due;
        bit                miss;
        bit                err;
        bit                chk;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t exp_vga_q[$];
    exp_t exp_cpu_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_note(input string name, input int act, input int exp);
        n_vec++;
        n_err++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] ref_mem [0:DEPTH-1];
    int                m_busy_until = -1;
    int                m_cnt = 0;
    logic [ADDR_W-1:0] m_last = '0;
    bit                cpu_active = 1'b0;

    task automatic cycle_step(input bit in_rst, input int p_vga, input int p_cpu, input int p_bad);
        int                c;
        bit                busy, inr, pend, bad, ewe;
        int                g;
        logic [ADDR_W-1:0] ea;
        @(posedge clk);
        #1;
        rst      = in_rst;
        c        = cyc;
        busy     = (c <= m_busy_until);
        vga_req  = ($urandom_range(0, 99) < p_vga);
        vga_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
        if (in_rst) begin
            cpu_active = 1'b0;
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
            cpu_wdata  = DATA_W'($urandom);
            cpu_req    = 1'($urandom_range(0, 1));
        end else begin
            if (!cpu_active && ($urandom_range(0, 99) < p_cpu)) begin
                cpu_active = 1'b1;
                cpu_we     = 1'($urandom_range(0, 1));
                cpu_wdata  = DATA_W'($urandom);
                if ($urandom_range(0, 99) < p_bad)
                    cpu_addr = ADDR_W'($urandom_range(64, DEPTH - 1));
                else
                    cpu_addr = ADDR_W'($urandom_range(0, 63));
            end
            cpu_req = cpu_active;
            if (cpu_req && busy && ($urandom_range(0, 9) == 0))
                cpu_req = 1'b0;
        end
        #1;
        if (in_rst) begin
            exp_vga_q.delete();
            exp_cpu_q.delete();
            m_busy_until = -1;
            m_cnt        = 0;
            m_last       = '0;
            return;
        end

        inr  = (int'(cpu_addr) < 64);
        pend = cpu_req && !busy && inr;
        bad  = cpu_req && !busy && !inr;
        if (pend && m_cnt == STARVE_MAX) g = 2;
        else if (vga_req)                g = 1;
        else if (pend)                   g = 2;
        else                             g = 0;

        ea  = (g == 1) ? vga_addr : (g == 2) ? cpu_addr : m_last;
        ewe = (g == 2) && cpu_we;
        check("mem_addr", 64'(mem_addr), 64'(ea));
        check("mem_we", 64'(mem_we), 64'(ewe));
        check("mem_wdata", 64'(mem_wdata), 64'(cpu_wdata));

        if (g == 1)
            exp_vga_q.push_back('{c + 2, 1'b0, 1'b0, 1'b1, ref_mem[vga_addr]});
        else if (vga_req)
            exp_vga_q.push_back('{c + 2, 1'b1, 1'b0, 1'b1, '0});

        if (g == 2 && cpu_we) begin
            exp_cpu_q.push_back('{c + 1, 1'b0, 1'b0, 1'b0, '0});
            ref_mem[cpu_addr] = cpu_wdata;
            m_busy_until = c + 1;
        end else if (g == 2) begin
            exp_cpu_q.push_back('{c + 2, 1'b0, 1'b0, 1'b1, ref_mem[cpu_addr]});
            m_busy_until = c + 2;
        end else if (bad) begin
            exp_cpu_q.push_back('{c + 1, 1'b0, 1'b1, 1'b1, '0});
            m_busy_until = c + 1;
        end

        if (g == 2)    m_cnt = 0;
        else if (pend) m_cnt = (m_cnt < STARVE_MAX) ? m_cnt + 1 : STARVE_MAX;
        else           m_cnt = 0;
        if (g != 0) m_last = ea;

        if (cpu_active && c == m_busy_until) cpu_active = 1'b0;
    endtask

    // ---------------- monitor ----------------
    logic [DATA_W-1:0] last_vga = '0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            last_vga = '0;
            check("rst_flags", 64'({vga_valid, vga_miss, cpu_ack, cpu_err, mem_we}), 64'(0));
            check("rst_vga_data", 64'(vga_data), 64'(0));
            check("rst_cpu_rdata", 64'(cpu_rdata), 64'(0));
            check("rst_mem_addr", 64'(mem_addr), 64'(0));
            check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        end else begin
            if (vga_valid || vga_miss) begin
                if (exp_vga_q.size() == 0) begin
                    fail_note("vga_unexpected", 1, 0);
                end else begin
                    e = exp_vga_q.pop_front();
                    check("vga_cycle", 64'(cyc), 64'(e.due));
                    check("vga_miss", 64'(vga_miss), 64'(e.miss));
                    check("vga_valid", 64'(vga_valid), 64'(!e.miss));
                    check("vga_data", 64'(vga_data), 64'(e.miss ? last_vga : e.data));
                    if (!e.miss) last_vga = e.data;
                end
            end else if (exp_vga_q.size() > 0 && exp_vga_q[0].due <= cyc) begin
                e = exp_vga_q.pop_front();
                fail_note("vga_missing", cyc, e.due);
            end

            if (cpu_ack) begin
                if (exp_cpu_q.size() == 0) begin
                    fail_note("cpu_ack_unexpected", 1, 0);
                end else begin
                    e = exp_cpu_q.pop_front();
                    check("cpu_ack_cycle", 64'(cyc), 64'(e.due));
                    check("cpu_err", 64'(cpu_err), 64'(e.err));
                    if (e.chk) check("cpu_rdata", 64'(cpu_rdata), 64'(e.data));
                end
            end else if (exp_cpu_q.size() > 0 && exp_cpu_q[0].due <= cyc) begin
                e = exp_cpu_q.pop_front();
                fail_note("cpu_ack_missing", cyc, e.due);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);

        repeat (3) cycle_step(1'b1, 50, 0, 0);
        // Full-rate VGA with a CPU request pending from the first cycle.
        repeat (60) cycle_step(1'b0, 100, 100, 0);
        repeat (600) cycle_step(1'b0, 50, 40, 15);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(3, 25)) cycle_step(1'b0, 60, 70, 10);
            repeat (2) cycle_step(1'b1, 50, 0, 0);
        end
        repeat (200) cycle_step(1'b0, 0, 80, 10);
        repeat (100) cycle_step(1'b0, 100, 100, 5);
        repeat (12) cycle_step(1'b0, 0, 0, 0);
        @(negedge clk);
        #1;
        check("vga_queue_drained", 64'(exp_vga_q.size()), 64'(0));
        check("cpu_queue_drained", 64'(exp_cpu_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
BOARD_MEM_ARBITER -- requirements
Module: board_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, the board memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, the board memory word width.
REQ-003 The block SHALL have parameter STARVE_MAX, default 16, the maximum number of cycles a CPU request waits before it is force-granted.
REQ-004 The block SHALL have port iVGA_CLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port iRST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port vga_req, input, 1 bit: the VGA fetch requests a square this cycle.
REQ-007 The block SHALL have port vga_addr, input, ADDR_W bits: the square address for the VGA fetch.
REQ-008 The block SHALL have port vga_data, output, DATA_W bits: the registered square word returned to VGA.
REQ-009 The block SHALL have port vga_valid, output, 1 bit: one-cycle pulse marking vga_data as new.
REQ-010 The block SHALL have port vga_miss, output, 1 bit: one-cycle pulse marking a VGA request that was not served.
REQ-011 The block SHALL have port cpu_req, input, 1 bit: CPU request, held until cpu_ack.
REQ-012 The block SHALL have port cpu_we, input, 1 bit: 1 = write, 0 = read.
REQ-013 The block SHALL have port cpu_addr, input, ADDR_W bits: the CPU square address.
REQ-014 The block SHALL have port cpu_wdata, input, DATA_W bits: the CPU write data.
REQ-015 The block SHALL have port cpu_ack, output, 1 bit: one-cycle completion pulse for the CPU request.
REQ-016 The block SHALL have port cpu_rdata, output, DATA_W bits: read data, valid while cpu_ack is high.
REQ-017 The block SHALL have port cpu_err, output, 1 bit: the completed request was rejected; valid while cpu_ack is high.
REQ-018 The block SHALL have ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_wdata (output, DATA_W) and mem_rdata (input, DATA_W), forming a single-port synchronous RAM interface with 1-cycle read latency.

Function
REQ-019 Grant priority each cycle SHALL be: (1) CPU, when a CPU request is pending and starve_cnt == STARVE_MAX; (2) otherwise VGA, when vga_req = 1; (3) otherwise CPU, when a CPU request is pending; (4) otherwise none.
REQ-020 A CPU request SHALL be pending when cpu_req = 1, the block is not busy and the request is not rejected.
REQ-021 "Busy" SHALL mean the window from a CPU grant, or from an error acceptance, through its cpu_ack; cpu_req SHALL be ignored while busy.
REQ-022 In the grant cycle N, the block SHALL drive mem_addr from the granted requester; mem_we SHALL equal cpu_we only on a CPU grant and SHALL be 0 otherwise; mem_wdata SHALL equal cpu_wdata.
REQ-023 When no requester is granted, mem_addr SHALL hold its last value and mem_we SHALL be 0.
REQ-024 For a VGA grant at cycle N, vga_data SHALL equal mem_rdata captured at the end of N+1, and vga_valid SHALL be 1 in cycle N+2 only.
REQ-025 For a CPU read granted at cycle N, cpu_rdata SHALL be the word captured at the end of N+1, and cpu_ack SHALL be 1 in cycle N+2 only.
REQ-026 For a CPU write granted at cycle N, cpu_ack SHALL be 1 in cycle N+1 only.
REQ-027 For a VGA request denied at cycle N, vga_miss SHALL be 1 in cycle N+2, vga_valid SHALL be 0, and vga_data SHALL hold its previous value.
REQ-028 starve_cnt SHALL increment every cycle a CPU request is pending and not granted, SHALL saturate at STARVE_MAX, SHALL clear on a CPU grant, and SHALL be 0 when no CPU request is pending.
REQ-029 A CPU request with cpu_addr[ADDR_W-1:6] != 0, i.e. outside the 64 board squares, SHALL never be driven to memory; on the first cycle the block sees it while not busy, the block SHALL enter busy, and in the next cycle cpu_ack = 1, cpu_err = 1 and cpu_rdata = 0.
REQ-030 cpu_err SHALL be 0 on every other ack; the block SHALL place no range check on vga_addr.
REQ-031 The FSM SHALL have states IDLE, VGA_RD, CPU_RD, CPU_WR and CPU_ERR, each naming the current-cycle grant.
REQ-032 A VGA read and a CPU read SHALL be allowed in flight in back-to-back cycles; a full-rate vga_req with a pending CPU request SHALL yield at most one CPU grant per STARVE_MAX+1 cycles.
REQ-033 When cpu_req deasserts before ack (a protocol violation), the granted operation SHALL still complete and ack.

Reset
REQ-034 While iRST = 1, all outputs SHALL be 0, the FSM SHALL be in IDLE, starve_cnt SHALL be 0 and all in-flight acks and valids SHALL be discarded.
REQ-035 Reset asserted mid-operation SHALL produce no cpu_ack, vga_valid or vga_miss after deassertion for any operation started before reset.
REQ-036 The first grant SHALL be possible in the first cycle after iRST deasserts.

Verification
REQ-037 VGA only, vga_req = 1, vga_addr = 5, RAM[5] = 32'h0000_0023 -> mem_addr = 5 at N; vga_data = 32'h23 with vga_valid at N+2.
REQ-038 CPU write, cpu_addr = 9, cpu_wdata = 32'hA1, no vga_req -> mem_we = 1 at N, cpu_ack at N+1; a subsequent read of address 9 -> cpu_rdata = 32'hA1 with cpu_ack at the read grant +2.
REQ-039 Starvation, vga_req held 1 and CPU read pending from cycle 0, STARVE_MAX = 16 -> CPU granted at cycle 16; vga_miss at cycle 18; VGA granted again at cycle 17.
REQ-040 Out-of-range access, cpu_addr = 12'h040 -> no mem_we and no memory access; cpu_ack = 1 with cpu_err = 1 and cpu_rdata = 0 one cycle after request.
REQ-041 Reset mid-read, iRST pulsed at N+1 of a CPU read -> no cpu_ack ever; all outputs 0 during reset; a new request after reset completes normally.
REQ-042 Simultaneous requests, vga_req and a CPU write both rising at cycle 0 with starve_cnt = 0 and vga_req dropping at cycle 1 -> VGA granted at 0; CPU granted at 1; cpu_ack at 2.
